// File: rtl/status_flag_unit.sv
// rtl/status_flag_unit.sv - 6502 processor status register with ALU flag alignment
//
// Purpose:
//   Holds the 7-bit P register (C,Z,I,D,B,V,N at bits 0..6). ALU flag updates
//   come in two parts. The sequencer issues the update mask together with the
//   alu_op. The ALU result flags arrive ALU_LATENCY cycles later. A small pipe
//   delays the mask so that it meets the result. The unit also handles
//   SEx/CLx, PLP/RTI loads, interrupt entry, the PHP/BRK push byte and branch
//   condition evaluation.
//
// Configuration:
//   STATUS_BYPASS_EN - when defined, branch_taken and p_push_byte are taken
//   from next-P, and flag_busy is tied to 0.
//
// Ports:
//   clk, rst_n     core clock; asynchronous active-low reset
//   alu_flags_in   registered ALU flags, valid on the aligned cycle
//   upd_valid      an ALU op issued this cycle will write flags
//   upd_mask       flags the issued op may write
//   set_mask       flags forced to 1 this cycle
//   clr_mask       flags forced to 0 this cycle (wins over set_mask)
//   p_load_valid   load P from p_load_data (stack format)
//   p_load_data    stack-format status byte
//   irq_entry      interrupt/BRK entry, sets I
//   push_brk       bit 4 of p_push_byte
//   branch_cond    branch opcode[7:5]
//   status_out     current P
//   p_push_byte    {N,V,1,push_brk,D,I,Z,C}
//   branch_taken   selected flag equals branch_cond[0]
//   flag_busy      an ALU update is still in the alignment pipe

module status_flag_unit #(
  parameter int ALU_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] alu_flags_in,
  input  logic       upd_valid,
  input  logic [6:0] upd_mask,
  input  logic [6:0] set_mask,
  input  logic [6:0] clr_mask,
  input  logic       p_load_valid,
  input  logic [7:0] p_load_data,
  input  logic       irq_entry,
  input  logic       push_brk,
  input  logic [2:0] branch_cond,
  output logic [6:0] status_out,
  output logic [7:0] p_push_byte,
  output logic       branch_taken,
  output logic       flag_busy
);

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_I = 2;
  localparam int FLAG_B = 4;
  localparam int FLAG_V = 5;
  localparam int FLAG_N = 6;

  localparam logic [6:0] P_RESET = 7'h04;

  logic [6:0]                  p_q;
  logic [6:0]                  p_d;
  logic [ALU_LATENCY-1:0]      pipe_valid_q;
  logic [ALU_LATENCY-1:0][6:0] pipe_mask_q;

  logic       aligned_valid;
  logic [6:0] aligned_mask;
  logic [6:0] load_p;
  logic [6:0] out_src;
  logic       sel_flag;

  // Bits 5 and 4 of the stack byte have no storage in P.
  logic unused_load_bits;
  assign unused_load_bits = ^p_load_data[5:4];

  // Mask alignment pipe: each op's mask travels on its own, one stage per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_q <= '0;
      pipe_mask_q  <= '0;
    end else begin
      pipe_valid_q[0] <= upd_valid;
      pipe_mask_q[0]  <= upd_mask;
      for (int i = 1; i < ALU_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_mask_q[i]  <= pipe_mask_q[i-1];
      end
    end
  end

  assign aligned_valid = pipe_valid_q[ALU_LATENCY-1];
  assign aligned_mask  = pipe_mask_q[ALU_LATENCY-1];

  // Stack byte bit positions: N=7, V=6, D..C=3..0; B is never stored.
  assign load_p = {p_load_data[7], p_load_data[6], 1'b0, p_load_data[3:0]};

  // Writers are applied lowest priority first so later ones override.
  always_comb begin
    p_d = p_q;
    if (p_load_valid) begin
      p_d = load_p;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (aligned_valid && aligned_mask[i]) begin
          p_d[i] = alu_flags_in[i];
        end
      end
      p_d = p_d | set_mask;
      p_d = p_d & ~clr_mask;
      if (irq_entry) begin
        p_d[FLAG_I] = 1'b1;
      end
    end
    p_d[FLAG_B] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= P_RESET;
    end else begin
      p_q <= p_d;
    end
  end

  assign status_out = p_q;

`ifdef STATUS_BYPASS_EN
  assign out_src   = p_d;
  assign flag_busy = 1'b0;
`else
  assign out_src   = p_q;
  assign flag_busy = |pipe_valid_q;
`endif

  assign p_push_byte = {out_src[FLAG_N], out_src[FLAG_V], 1'b1, push_brk, out_src[3:0]};

  // branch_cond[2:1]: 00=N, 01=V, 10=C, 11=Z
  always_comb begin
    sel_flag = 1'b0;
    case (branch_cond[2:1])
      2'b00:   sel_flag = out_src[FLAG_N];
      2'b01:   sel_flag = out_src[FLAG_V];
      2'b10:   sel_flag = out_src[FLAG_C];
      default: sel_flag = out_src[FLAG_Z];
    endcase
  end

  assign branch_taken = (sel_flag == branch_cond[0]);

endmodule

// File: doc/status_flag_unit.md
Name: status_flag_unit

Overview:
- Owns the 7-bit processor status register (P) of the 6502 core.
- Consumes the registered flag vector the ALU produces one cycle after an op is issued, and merges it into P under a per-bit update mask.
- The mask is issued by the control sequencer in the same cycle as the alu_op, so the unit delays it to line up with the ALU result.
- Also handles SEx/CLx, PLP load, interrupt entry, the PHP/BRK push byte and branch-condition evaluation.

Parameters:
- ALU_LATENCY, 1, cycles between alu_op issue and valid ALU flags; legal values 1..2; sets the depth of the mask-alignment pipe.

Ports:
- clk  input  1  core clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- alu_flags_in  input  7  registered ALU flag output, indexed by the status-register include macros (C, Z, I, D, B, V, N)
- upd_valid  input  1  an ALU op issued this cycle will update flags
- upd_mask  input  7  flags that op may write; sampled with upd_valid
- set_mask  input  7  force listed flags to 1 this cycle (SEC/SEI/SED)
- clr_mask  input  7  force listed flags to 0 this cycle (CLC/CLI/CLD/CLV)
- p_load_valid  input  1  PLP/RTI: load P from p_load_data
- p_load_data  input  8  stack-format status byte
- irq_entry  input  1  interrupt/BRK entry; sets I
- push_brk  input  1  value placed in bit 4 of p_push_byte
- branch_cond  input  3  opcode[7:5] of a branch: [2:1] selects N/V/C/Z (00/01/10/11), [0] is the required value
- status_out  output  7  current P
- p_push_byte  output  8  {N,V,1,push_brk,D,I,Z,C}; combinational from status_out
- branch_taken  output  1  selected flag equals branch_cond[0]
- flag_busy  output  1  an aligned ALU update is still pending

Behaviour:
- Reset (asynchronous, rst_n low):
  - status_out: I=1, all other bits 0.
  - Alignment pipe: cleared (no pending updates). flag_busy=0.
  - Reset asserted mid-operation discards any in-flight update; nothing is applied after release.
- Alignment pipe:
  - ALU_LATENCY stages, each holding {valid, mask[6:0]}.
  - Stage 0 loads {upd_valid, upd_mask}. Stage k loads stage k-1.
  - The last stage is the "aligned update": bits in its mask take alu_flags_in in the cycle it is valid.
- flag_busy: OR of valid across all stages.
- B bit of P is held at 0 by every write path; it exists only in p_push_byte.
- Next-P per bit, highest priority first:
  1. p_load_valid: bit := p_load_data at the 8-bit position; bits 5 and 4 of p_load_data are ignored. An aligned update in the same cycle is dropped. set_mask, clr_mask and irq_entry are ignored that cycle.
  2. irq_entry: I := 1.
  3. clr_mask bit: 0. If a bit is in both clr_mask and set_mask, clear wins.
  4. set_mask bit: 1.
  5. Aligned update with the mask bit set: alu_flags_in bit.
  6. Otherwise hold.
- Back-to-back ALU ops:
  - Each op's mask travels independently.
  - An update arriving at the last stage every cycle is applied every cycle; none are lost or merged.
- Branch evaluation: branch_taken = P[sel] == branch_cond[0], combinational from status_out (see optional feature).
- p_push_byte: bit 5 is always 1, bit 4 = push_brk, all other bits from status_out.
- No state other than P and the alignment pipe.

Optional Feature:
- Macro: STATUS_BYPASS_EN.
- Defined:
  - branch_taken and p_push_byte are computed from next-P, so the value includes this cycle's aligned update, set/clr and load.
  - A branch or PHP immediately after a flag-writing op needs no stall.
  - flag_busy is tied to 0.
- Undefined:
  - Both outputs derive from registered status_out.
  - flag_busy behaves as specified above; the sequencer stalls branches and PHP while it is high.

Test Plan:
- Reset: rst_n=0 mid-cycle -> status_out immediately I=1, others 0; p_push_byte=8'h24 with push_brk=0. A pipe loaded before reset applies nothing after release.
- Aligned update (ALU_LATENCY=1):
  - Cycle 0: upd_valid=1, mask={C,Z,N}.
  - Cycle 1: alu_flags_in = C=1, Z=0, N=1, V=1.
  - Cycle 2: status_out has C=1, N=1, Z=0, V unchanged 0.
  - flag_busy high in cycle 1 only.
- Priority collision: aligned update writing C=1, same cycle clr_mask={C}, set_mask={C,D} -> C=0, D=1. With p_load_valid=1 and p_load_data=8'hC3 in that cycle instead -> P has N=1, V=1, Z=1, C=1, B=0, I=0, D=0.
- PLP B/unused stripping: p_load_data=8'h30 -> all P bits 0; p_push_byte=8'h30 when push_brk=1.
- Branch: Z=1, branch_cond=3'b111 (BEQ) -> taken=1; 3'b110 (BNE) -> 0; C=0, 3'b100 (BCC) -> 1.
- Back-to-back, ALU_LATENCY=2:
  - Three consecutive ops with masks {C}, {Z}, {N}; ALU flags all ones on their aligned cycles.
  - C, Z, N become 1 in successive cycles 3, 4, 5.
  - flag_busy high cycles 1-4 without bypass; always 0 with STATUS_BYPASS_EN.
